// File: rtl/sys_bus_regbank_pkg.sv
// Shared definitions for the system-bus housekeeping register bank:
// register offsets, control bit positions and the response pipeline word.
package sys_bus_regbank_pkg;

    localparam logic [31:0] REG_ID       = 32'h00;
    localparam logic [31:0] REG_SCRATCH  = 32'h04;
    localparam logic [31:0] REG_LED      = 32'h08;
    localparam logic [31:0] REG_CNT_LO   = 32'h10;
    localparam logic [31:0] REG_CNT_HI   = 32'h14;
    localparam logic [31:0] REG_CNT_CTRL = 32'h18;

    localparam int unsigned CNT_CTRL_EN  = 0;
    localparam int unsigned CNT_CTRL_CLR = 1;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] rdata;
    } sys_rsp_t;

endpackage

// File: rtl/sys_bus_rsp_pipe.sv
// Fixed-depth shift register carrying bus responses from decode to the bus outputs.
// A synchronous flush drops every response still in flight.
module sys_bus_rsp_pipe
    import sys_bus_regbank_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk_i,
    input  logic     flush_i,
    input  sys_rsp_t rsp_i,
    output sys_rsp_t rsp_o
);

    sys_rsp_t stage_q [Depth];

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= rsp_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/sys_bus_regbank.sv
// Baseline PS system-bus responder: ID, scratch, LED and a 64-bit cycle counter
// whose high word is captured into a shadow whenever the low word is read.
module sys_bus_regbank
    import sys_bus_regbank_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h5250_0001,
    parameter int unsigned ACK_LAT  = 1,
    parameter int unsigned ADDR_W   = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] sys_addr_i,
    input  logic [31:0] sys_wdata_i,
    input  logic        sys_wen_i,
    input  logic        sys_ren_i,
    output logic [31:0] sys_rdata_o,
    output logic        sys_err_o,
    output logic        sys_ack_o,
    output logic [7:0]  led_o
);

    logic [ADDR_W-1:0] offset;
    logic              unused_addr;
    logic              mapped, writable, err, do_wr, do_rd;
    logic [31:0]       rd_val;
    sys_rsp_t          rsp_in, rsp_out;

    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  led_q, led_d;
    logic [63:0] cnt_q, cnt_d;
    logic        cnt_en_q, cnt_en_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;

    assign offset      = sys_addr_i[ADDR_W-1:0];
    assign unused_addr = ^sys_addr_i[31:ADDR_W];

    always_comb begin
        mapped   = 1'b1;
        writable = 1'b0;
        rd_val   = '0;
        case (offset)
            ADDR_W'(REG_ID):       rd_val = ID_VALUE;
            ADDR_W'(REG_SCRATCH): begin
                rd_val   = scratch_q;
                writable = 1'b1;
            end
            ADDR_W'(REG_LED): begin
                rd_val   = {24'h0, led_q};
                writable = 1'b1;
            end
            ADDR_W'(REG_CNT_LO):   rd_val = cnt_q[31:0];
            ADDR_W'(REG_CNT_HI):   rd_val = hi_shadow_q;
            ADDR_W'(REG_CNT_CTRL): begin
                rd_val   = {31'h0, cnt_en_q};
                writable = 1'b1;
            end
            default:               mapped = 1'b0;
        endcase

        err = (sys_wen_i || sys_ren_i) &&
              ((sys_wen_i && sys_ren_i) || (offset[1:0] != 2'b00) || !mapped ||
               (sys_wen_i && !writable));
        do_wr = sys_wen_i && !err;
        do_rd = sys_ren_i && !err;

        rsp_in.ack   = sys_wen_i || sys_ren_i;
        rsp_in.err   = err;
        rsp_in.rdata = do_rd ? rd_val : 32'h0;
    end

    always_comb begin
        scratch_d   = scratch_q;
        led_d       = led_q;
        cnt_en_d    = cnt_en_q;
        hi_shadow_d = hi_shadow_q;
        cnt_d       = cnt_en_q ? cnt_q + 64'd1 : cnt_q;

        if (do_wr) begin
            case (offset)
                ADDR_W'(REG_SCRATCH):  scratch_d = sys_wdata_i;
                ADDR_W'(REG_LED):      led_d     = sys_wdata_i[7:0];
                ADDR_W'(REG_CNT_CTRL): begin
                    cnt_en_d = sys_wdata_i[CNT_CTRL_EN];
                    // Clear wins over the increment of this same edge.
                    if (sys_wdata_i[CNT_CTRL_CLR]) begin
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        if (do_rd && (offset == ADDR_W'(REG_CNT_LO))) begin
            hi_shadow_d = cnt_q[63:32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scratch_q   <= '0;
            led_q       <= '0;
            cnt_q       <= '0;
            cnt_en_q    <= 1'b1;
            hi_shadow_q <= '0;
        end else begin
            scratch_q   <= scratch_d;
            led_q       <= led_d;
            cnt_q       <= cnt_d;
            cnt_en_q    <= cnt_en_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

    sys_bus_rsp_pipe #(
        .Depth (ACK_LAT)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .rsp_i   (rsp_in),
        .rsp_o   (rsp_out)
    );

    assign sys_ack_o   = rsp_out.ack;
    assign sys_err_o   = rsp_out.err;
    assign sys_rdata_o = rsp_out.rdata;
    assign led_o       = led_q;

endmodule

// File: tb/tb_sys_bus_regbank.sv
// Scoreboard bench: requests push expected responses, per-DUT monitors pop on ack.
module tb_sys_bus_regbank;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // ACK_LAT=1 instance
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [31:0] rdata;
    logic        err, ack;
    logic [7:0]  led;
    exp_t        q1 [$];
    logic        mon1_en = 1'b0;

    // ACK_LAT=3 instance
    logic        rst3 = 1'b1;
    logic [31:0] addr3 = '0, wdata3 = '0;
    logic        wen3 = 1'b0, ren3 = 1'b0;
    logic [31:0] rdata3;
    logic        err3, ack3;
    logic [7:0]  led3;
    exp_t        q3 [$];
    logic        mon3_en = 1'b0;
    int          acks3 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_bus_regbank #(
        .ID_VALUE (32'h5250_0001),
        .ACK_LAT  (1),
        .ADDR_W   (20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sys_addr_i  (addr),
        .sys_wdata_i (wdata),
        .sys_wen_i   (wen),
        .sys_ren_i   (ren),
        .sys_rdata_o (rdata),
        .sys_err_o   (err),
        .sys_ack_o   (ack),
        .led_o       (led)
    );

    sys_bus_regbank #(
        .ID_VALUE (32'h5250_0001),
        .ACK_LAT  (3),
        .ADDR_W   (20)
    ) dut3 (
        .clk_i       (clk),
        .rst_i       (rst3),
        .sys_addr_i  (addr3),
        .sys_wdata_i (wdata3),
        .sys_wen_i   (wen3),
        .sys_ren_i   (ren3),
        .sys_rdata_o (rdata3),
        .sys_err_o   (err3),
        .sys_ack_o   (ack3),
        .led_o       (led3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors sample on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon1_en) begin
            if (ack) begin
                if (q1.size() == 0) begin
                    chk("lat1_unexpected_ack", 64'(ack), 64'(0));
                end else begin
                    e = q1.pop_front();
                    chk("lat1_latency", 64'(cyc - e.cyc), 64'(1));
                    chk("lat1_err", 64'(err), 64'(e.err));
                    chk("lat1_rdata", 64'(rdata), 64'(e.rdata));
                end
            end else begin
                chk("lat1_idle_zero", {31'h0, err, rdata}, 64'h0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon3_en && ack3) begin
            acks3++;
            if (q3.size() == 0) begin
                chk("lat3_unexpected_ack", 64'(ack3), 64'(0));
            end else begin
                e = q3.pop_front();
                chk("lat3_latency", 64'(cyc - e.cyc), 64'(3));
                chk("lat3_err", 64'(err3), 64'(e.err));
                chk("lat3_rdata", 64'(rdata3), 64'(e.rdata));
            end
        end
    end

    // One-cycle strobe on the ACK_LAT=1 instance; called at a falling edge.
    task automatic bus(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rdata);
        exp_t e;
        wen   = w;
        ren   = r;
        addr  = a;
        wdata = d;
        e.err = e_err;
        e.rdata = e_rdata;
        e.cyc = cyc;
        q1.push_back(e);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic read3(input logic [31:0] a, input logic expect_ack, input logic [31:0] e_rdata);
        exp_t e;
        ren3  = 1'b1;
        addr3 = a;
        if (expect_ack) begin
            e.err = 1'b0;
            e.rdata = e_rdata;
            e.cyc = cyc;
            q3.push_back(e);
        end
        @(negedge clk);
        ren3 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst3 = 1'b0;
        mon1_en = 1'b1;
        mon3_en = 1'b1;
        @(negedge clk);

        // Reset state and basic reads
        chk("reset_led", 64'(led), 64'h00);
        bus(0, 1, 32'h00, 0, 0, 32'h5250_0001);
        bus(0, 1, 32'h08, 0, 0, 32'h0);
        chk("reset_led_after_read", 64'(led), 64'h00);

        // Scratch and LED write/read-back
        bus(1, 0, 32'h04, 32'hDEAD_BEEF, 0, 32'h0);
        bus(0, 1, 32'h04, 0, 0, 32'hDEAD_BEEF);
        bus(1, 0, 32'h08, 32'h0000_01A5, 0, 32'h0);
        chk("led_after_write", 64'(led), 64'hA5);
        bus(0, 1, 32'h08, 0, 0, 32'h0000_00A5);

        // Counter: stop, preload across a low-word wrap, restart, snapshot
        bus(1, 0, 32'h18, 32'h0, 0, 32'h0);
        force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        bus(1, 0, 32'h18, 32'h1, 0, 32'h0);
        bus(0, 1, 32'h10, 0, 0, 32'hFFFF_FFFF);
        idle(9);
        bus(0, 1, 32'h14, 0, 0, 32'h0000_0001);

        // Clear plus enable: four increments after the clearing edge
        bus(1, 0, 32'h18, 32'h3, 0, 32'h0);
        idle(4);
        bus(0, 1, 32'h10, 0, 0, 32'h0000_0005 - 32'h1);
        bus(0, 1, 32'h14, 0, 0, 32'h0);
        bus(0, 1, 32'h18, 0, 0, 32'h1);

        // Error responses with no side effects
        bus(1, 0, 32'h00, 32'h1111_1111, 1, 32'h0);
        bus(0, 1, 32'h0C, 0, 1, 32'h0);
        bus(0, 1, 32'h06, 0, 1, 32'h0);
        bus(1, 1, 32'h04, 32'h1234_5678, 1, 32'h0);
        bus(1, 0, 32'h10, 32'h0, 1, 32'h0);
        bus(0, 1, 32'h04, 0, 0, 32'hDEAD_BEEF);
        bus(0, 1, 32'h14, 0, 0, 32'h0);
        // Address bits above ADDR_W are ignored
        bus(0, 1, 32'hFFF0_0004, 0, 0, 32'hDEAD_BEEF);
        idle(3);
        chk("lat1_drained", 64'(q1.size()), 64'(0));

        // ACK_LAT=3: three reads in flight, reset in the following cycle.
        // Only the first response reaches the outputs before the flush edge.
        read3(32'h00, 1, 32'h5250_0001);
        read3(32'h04, 0, 32'h0);
        read3(32'h08, 0, 32'h0);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        idle(6);
        chk("lat3_acks_after_flush", 64'(acks3), 64'(1));
        chk("lat3_flushed_queue", 64'(q3.size()), 64'(0));
        read3(32'h00, 1, 32'h5250_0001);
        idle(4);
        chk("lat3_acks_after_new_read", 64'(acks3), 64'(2));
        chk("lat3_drained", 64'(q3.size()), 64'(0));

        mon1_en = 1'b0;
        mon3_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_bus_regbank.md
Name: sys_bus_regbank

Overview:
- Responder (slave) end of the PS system bus: accepts single-cycle write/read strobes issued by the PS-side bus bridge and returns data with ack/err after a fixed latency.
- Provides a small housekeeping register bank: ID, scratch, LED control, and a 64-bit free-running cycle counter with atomic snapshot.
- Sits in the FPGA fabric beside the `system` block instance.
- Serves as the baseline responder that application modules are cloned from.

Parameters:
- ID_VALUE, 32'h5250_0001, constant returned by the ID register.
- ACK_LAT, 1, cycles from request strobe to ack; legal range 1..4.
- ADDR_W, 20, number of low address bits decoded; higher bits are ignored.

Ports:
- clk_i  in  1  system bus clock.
- rst_i  in  1  reset; synchronous, active-high.
- sys_addr_i  in  32  byte address, sampled on a strobe.
- sys_wdata_i  in  32  write data, sampled with sys_wen_i.
- sys_wen_i  in  1  single-cycle write strobe.
- sys_ren_i  in  1  single-cycle read strobe.
- sys_rdata_o  out  32  read data, valid when sys_ack_o=1.
- sys_err_o  out  1  error flag, valid when sys_ack_o=1.
- sys_ack_o  out  1  single-cycle acknowledge.
- led_o  out  8  LED register contents.

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (rst_i).
- Reset values: sys_ack_o=0, sys_err_o=0, sys_rdata_o=0, led_o=0, scratch=0, counter=0, counter enable=1, hi shadow=0, latency pipeline cleared.
- Register map (offset = sys_addr_i[ADDR_W-1:0]):
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x04 SCRATCH: read/write, 32 bits.
  - 0x08 LED: read/write; bits [7:0] drive led_o; reads return zero in [31:8].
  - 0x10 CNT_LO: read-only. Returns counter[31:0]. In the same cycle, counter[63:32] is copied into the hi shadow.
  - 0x14 CNT_HI: read-only. Returns the hi shadow, not the live counter.
  - 0x18 CNT_CTRL: bit0=enable (read/write); bit1=clear (write-1 pulse, always reads 0).
- Request cycle N (a strobe is high):
  - Decode, write effect, and read-data capture all happen at edge N.
  - Response appears at cycle N+ACK_LAT via a shift pipeline of {ack, err, rdata}.
  - With ACK_LAT=1, outputs are registered directly. Back-to-back requests on consecutive cycles are accepted, and each produces its own ack.
- Error cases. Each gives an ack with err=1 and rdata=0, and has no side effect:
  - unmapped offset;
  - sys_addr_i[1:0] != 0;
  - write to ID, CNT_LO or CNT_HI;
  - sys_wen_i and sys_ren_i both high. In this case the write is also suppressed.
  - A read of an unmapped or misaligned address does not touch the hi shadow.
- Counter:
  - Increments by 1 each cycle while enable=1.
  - Wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - Writing clear=1 loads 0 at that edge. Clear takes priority over the increment in the same cycle. Counting resumes the following cycle if enable=1 after the write.
  - A CNT_LO read returns the pre-increment value sampled at edge N, and the shadow is taken from that same value.
- Writes take effect at edge N. A read of the same register at N+1 returns the new value.
- Reset asserted while responses are in flight: the pipeline is flushed, and no ack is ever issued for those requests.
- No strobe: ack=0. rdata and err hold 0 whenever ack=0.

Decomposition:
- Shared package sys_bus_regbank_pkg holds:
  - register offset localparams (REG_ID, REG_SCRATCH, REG_LED, REG_CNT_LO, REG_CNT_HI, REG_CNT_CTRL);
  - CNT_CTRL bit indices;
  - a packed struct sys_rsp_t {ack, err, rdata[31:0]} used by the latency pipeline.
- One sub-module, sys_bus_rsp_pipe: a parameterised ACK_LAT-deep shift register of sys_rsp_t with synchronous flush.

Test Plan:
- After reset, read 0x00 → ack exactly ACK_LAT cycles later, rdata=32'h5250_0001, err=0. Read 0x08 → 0, and led_o=8'h00.
- Write 0x04=32'hDEAD_BEEF, then read 0x04 on the next cycle → rdata=32'hDEAD_BEEF. Write 0x08=32'h0000_01A5 → led_o=8'hA5, and a read of 0x08 returns 32'h0000_00A5.
- Set counter enable=0, then force counter=64'h0000_0001_FFFF_FFFF via a debug force. Set enable=1, read CNT_LO, then read CNT_HI 10 cycles later → LO=32'hFFFF_FFFF, HI=1 (the shadow is stable despite the wrap).
- Write CNT_CTRL=3 (clear and enable together), then read CNT_LO 5 cycles later → a small value counted from 0, with no residue from the prior count.
- Write to 0x00, read 0x0C, read 0x06, and raise wen+ren together on 0x04 → four acks, each with err=1 and rdata=0, and scratch unchanged.
- ACK_LAT=3: issue reads on 3 consecutive cycles, then assert rst_i for 1 cycle mid-flight → no ack follows the reset. A new read afterwards acks after 3 cycles.
